// File: rtl/dmem_pkg.sv
// Shared constants and helpers for the MEM-stage data-memory sequencer.
package dmem_pkg;

    // RV32I load/store size encodings (inst[14:12])
    localparam logic [2:0] F3_B  = 3'd0;
    localparam logic [2:0] F3_H  = 3'd1;
    localparam logic [2:0] F3_W  = 3'd2;
    localparam logic [2:0] F3_BU = 3'd4;
    localparam logic [2:0] F3_HU = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2,
        DONE = 2'd3
    } state_t;

    // Halfwords need an even address, words a 4-byte aligned one.
    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] lo);
        case (f3[1:0])
            2'd1:    return lo[0];
            2'd2:    return (lo != 2'b00);
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/dmem_lane_fmt.sv
// Byte-lane steering: store masks / replicated store data, and load
// extraction with sign or zero extension.
module dmem_lane_fmt
    import dmem_pkg::*;
(
    input  logic [2:0]  st_funct3,
    input  logic [1:0]  st_addr_lo,
    input  logic        st_we,
    input  logic [31:0] st_data,
    output logic [3:0]  mask,
    output logic [31:0] st_wdata,
    input  logic [2:0]  ld_funct3,
    input  logic [1:0]  ld_addr_lo,
    input  logic [31:0] ld_word,
    output logic [31:0] ld_data
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    // Store side: replicate the operand on every lane so the mask alone picks the target bytes.
    always_comb begin
        mask     = 4'hF;
        st_wdata = st_data;
        if (st_we) begin
            case (st_funct3)
                F3_B: begin
                    mask     = 4'b0001 << st_addr_lo;
                    st_wdata = {4{st_data[7:0]}};
                end
                F3_H: begin
                    mask     = 4'b0011 << {st_addr_lo[1], 1'b0};
                    st_wdata = {2{st_data[15:0]}};
                end
                default: begin
                    mask     = 4'hF;
                    st_wdata = st_data;
                end
            endcase
        end
    end

    // Load side: pick the addressed byte/half from the bus word, then extend it.
    always_comb begin
        case (ld_addr_lo)
            2'd0:    byte_sel = ld_word[7:0];
            2'd1:    byte_sel = ld_word[15:8];
            2'd2:    byte_sel = ld_word[23:16];
            default: byte_sel = ld_word[31:24];
        endcase
        half_sel = ld_addr_lo[1] ? ld_word[31:16] : ld_word[15:0];
        case (ld_funct3)
            F3_B:    ld_data = {{24{byte_sel[7]}}, byte_sel};
            F3_BU:   ld_data = {24'd0, byte_sel};
            F3_H:    ld_data = {{16{half_sel[15]}}, half_sel};
            F3_HU:   ld_data = {16'd0, half_sel};
            default: ld_data = ld_word;
        endcase
    end

endmodule

// File: rtl/dmem_seq.sv
// Multicycle data-memory access sequencer for the RV32I MEM stage.
// Drives a req/gnt/rvalid bus, stalls the pipeline while busy and
// reports illegal accesses or bus timeouts as a one-cycle fault.
module dmem_seq
    import dmem_pkg::*;
#(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 8
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_valid,
    input  logic        i_dmem_ren,
    input  logic        i_dmem_wen,
    input  logic [2:0]  i_funct3,
    input  logic [31:0] i_addr,
    input  logic [31:0] i_wdata,
    output logic        o_stall,
    output logic        o_done,
    output logic [31:0] o_rdata,
    output logic        o_fault,
    output logic        o_bus_req,
    output logic        o_bus_we,
    output logic [31:0] o_bus_addr,
    output logic [31:0] o_bus_wdata,
    output logic [3:0]  o_bus_mask,
    input  logic        i_bus_gnt,
    input  logic        i_bus_rvalid,
    input  logic [31:0] i_bus_rdata
);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [2:0]       f3_q;
    logic [1:0]       lo_q;

    logic        busy;
    logic        timeout;
    logic        acc_req;
    logic        bad_f3;
    logic        bad_align;
    logic        illegal;
    logic        accept;
    logic [3:0]  lane_mask;
    logic [31:0] lane_wdata;
    logic [31:0] load_data;

    dmem_lane_fmt u_lane_fmt (
        .st_funct3  (i_funct3),
        .st_addr_lo (i_addr[1:0]),
        .st_we      (i_dmem_wen),
        .st_data    (i_wdata),
        .mask       (lane_mask),
        .st_wdata   (lane_wdata),
        .ld_funct3  (f3_q),
        .ld_addr_lo (lo_q),
        .ld_word    (i_bus_rdata),
        .ld_data    (load_data)
    );

    // Request decode and legality checks; the timeout wins over any same-cycle gnt/rvalid.
    always_comb begin
        busy      = (state == REQ) || (state == WAIT);
        timeout   = busy && (TIMEOUT != 0) && (cnt == CNT_W'(TIMEOUT));
        acc_req   = i_valid && (i_dmem_ren ^ i_dmem_wen);
        bad_f3    = i_dmem_ren ? ((i_funct3 == 3'd3) || (i_funct3[2:1] == 2'b11))
                               : (i_funct3 > 3'd2);
        bad_align = misaligned(i_funct3, i_addr[1:0]);
        illegal   = (i_valid && i_dmem_ren && i_dmem_wen) || (acc_req && (bad_f3 || bad_align));
        accept    = (state == IDLE) && acc_req && !bad_f3 && !bad_align;
        o_stall   = (busy && !timeout) || accept;
        o_fault   = ((state == IDLE) && illegal) || timeout;
        o_bus_req = (state == REQ) && !timeout;
        o_done    = (state == DONE);
    end

    // Sequencer FSM: latch the access in IDLE, hand it to the bus, collect the response.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            f3_q        <= 3'd0;
            lo_q        <= 2'd0;
            o_bus_we    <= 1'b0;
            o_bus_addr  <= 32'd0;
            o_bus_wdata <= 32'd0;
            o_bus_mask  <= 4'd0;
            o_rdata     <= 32'd0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        f3_q        <= i_funct3;
                        lo_q        <= i_addr[1:0];
                        o_bus_we    <= i_dmem_wen;
                        o_bus_addr  <= {i_addr[31:2], 2'b00};
                        o_bus_wdata <= lane_wdata;
                        o_bus_mask  <= lane_mask;
                        cnt         <= '0;
                        state       <= REQ;
                    end
                end
                REQ: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (i_bus_gnt) begin
                        cnt   <= '0;
                        state <= o_bus_we ? DONE : WAIT;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                WAIT: begin
                    if (timeout) begin
                        state <= IDLE;
                    end else if (i_bus_rvalid) begin
                        o_rdata <= load_data;
                        state   <= DONE;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_seq.sv
// Directed bench for dmem_seq: a bus responder, a response scoreboard
// and directed load/store/fault/timeout/reset vectors.
module tb_dmem_seq;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        i_dmem_ren = 1'b0;
    logic        i_dmem_wen = 1'b0;
    logic [2:0]  i_funct3 = 3'd0;
    logic [31:0] i_addr = 32'd0;
    logic [31:0] i_wdata = 32'd0;
    logic        i_bus_gnt = 1'b0;
    logic        i_bus_rvalid = 1'b0;
    logic [31:0] i_bus_rdata = 32'd0;
    logic        o_stall, o_done, o_fault, o_bus_req, o_bus_we;
    logic [31:0] o_rdata, o_bus_addr, o_bus_wdata;
    logic [3:0]  o_bus_mask;

    int nCompared = 0;
    int nMismatched = 0;

    // Bus responder settings (gntDelay == 0 means never grant)
    int          gntDelay = 1;
    int          rvalidDelay = 1;
    logic [31:0] respWord = 32'd0;
    int          reqSeen = 0;
    bit          rvPending = 0;
    int          rvLeft = 0;

    // Scoreboard queues
    bit          expFaultQ[$];
    logic [31:0] expRdataQ[$];
    string       expNameQ[$];
    logic [31:0] busAddrQ[$];
    bit          busWeQ[$];
    logic [3:0]  busMaskQ[$];
    logic [31:0] busWdataQ[$];

    always #5 i_clk = ~i_clk;

    dmem_seq #(.TIMEOUT(4), .CNT_W(8)) dut (
        .i_clk        (i_clk),
        .i_rst        (i_rst),
        .i_valid      (i_valid),
        .i_dmem_ren   (i_dmem_ren),
        .i_dmem_wen   (i_dmem_wen),
        .i_funct3     (i_funct3),
        .i_addr       (i_addr),
        .i_wdata      (i_wdata),
        .o_stall      (o_stall),
        .o_done       (o_done),
        .o_rdata      (o_rdata),
        .o_fault      (o_fault),
        .o_bus_req    (o_bus_req),
        .o_bus_we     (o_bus_we),
        .o_bus_addr   (o_bus_addr),
        .o_bus_wdata  (o_bus_wdata),
        .o_bus_mask   (o_bus_mask),
        .i_bus_gnt    (i_bus_gnt),
        .i_bus_rvalid (i_bus_rvalid),
        .i_bus_rdata  (i_bus_rdata)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        nCompared++;
        if (actual !== expected) begin
            nMismatched++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    // Bus responder: grants after gntDelay request cycles, returns read data rvalidDelay cycles after gnt
    always @(negedge i_clk) begin
        i_bus_gnt = 1'b0;
        i_bus_rvalid = 1'b0;
        if (rvPending) begin
            rvLeft--;
            if (rvLeft == 0) begin
                i_bus_rvalid = 1'b1;
                i_bus_rdata = respWord;
                rvPending = 0;
            end
        end
        if (o_bus_req) begin
            reqSeen++;
            if (gntDelay != 0 && reqSeen == gntDelay) begin
                i_bus_gnt = 1'b1;
                reqSeen = 0;
                if (busAddrQ.size() == 0) begin
                    checkOutput("unexpected_bus_req", 32'd1, 32'd0);
                end else begin
                    checkOutput("bus_addr", o_bus_addr, busAddrQ.pop_front());
                    checkOutput("bus_mask", {28'd0, o_bus_mask}, {28'd0, busMaskQ.pop_front()});
                    if (busWeQ.pop_front()) begin
                        checkOutput("bus_we", {31'd0, o_bus_we}, 32'd1);
                        checkOutput("bus_wdata", o_bus_wdata, busWdataQ.pop_front());
                    end else begin
                        checkOutput("bus_we", {31'd0, o_bus_we}, 32'd0);
                        void'(busWdataQ.pop_front());
                    end
                end
                if (!o_bus_we) begin
                    rvPending = 1;
                    rvLeft = rvalidDelay;
                end
            end
        end else begin
            reqSeen = 0;
        end
    end

    // Response monitor: every done/fault pulse is matched against the scoreboard
    always begin
        @(negedge i_clk);
        #2;
        if (!i_rst && (o_done || o_fault)) begin
            if (expFaultQ.size() == 0) begin
                checkOutput("unexpected_response", 32'd1, 32'd0);
            end else begin
                string nm;
                nm = expNameQ.pop_front();
                checkOutput({nm, "_kind_fault"}, {31'd0, o_fault}, {31'd0, expFaultQ.pop_front()});
                checkOutput({nm, "_rdata"}, o_rdata, expRdataQ.pop_front());
            end
        end
    end

    // kind: 0 = completes, 1 = illegal access fault, 2 = bus timeout
    task automatic applyStimulus(input string name, input logic ren, input logic wen,
                                 input logic [2:0] f3, input logic [31:0] addr, input logic [31:0] wdata,
                                 input int d, input int r, input logic [31:0] resp, input int kind,
                                 input logic [31:0] expRdata, input logic [3:0] expMask,
                                 input logic [31:0] expBusWdata, input int expCycles, input int expReq);
        int cycles;
        int reqCycles;
        bit ended;
        bit stallOk;
        @(negedge i_clk);
        gntDelay = d;
        rvalidDelay = r;
        respWord = resp;
        if (kind == 0) begin
            busAddrQ.push_back({addr[31:2], 2'b00});
            busWeQ.push_back(wen);
            busMaskQ.push_back(expMask);
            busWdataQ.push_back(expBusWdata);
        end
        expFaultQ.push_back(kind != 0);
        expRdataQ.push_back(expRdata);
        expNameQ.push_back(name);
        i_valid = 1'b1;
        i_dmem_ren = ren;
        i_dmem_wen = wen;
        i_funct3 = f3;
        i_addr = addr;
        i_wdata = wdata;
        #1;
        if (kind == 1) begin
            checkOutput({name, "_fault_now"}, {31'd0, o_fault}, 32'd1);
            checkOutput({name, "_no_stall"}, {31'd0, o_stall}, 32'd0);
            @(negedge i_clk);
            i_valid = 1'b0;
            i_dmem_ren = 1'b0;
            i_dmem_wen = 1'b0;
            #1;
            checkOutput({name, "_no_req"}, {31'd0, o_bus_req}, 32'd0);
        end else begin
            checkOutput({name, "_stall_c1"}, {31'd0, o_stall}, 32'd1);
            cycles = 1;
            reqCycles = 0;
            ended = 0;
            stallOk = 1;
            while (!ended && cycles < 20) begin
                @(negedge i_clk);
                if (cycles == 1) begin
                    i_valid = 1'b0;
                    i_dmem_ren = 1'b0;
                    i_dmem_wen = 1'b0;
                end
                cycles++;
                #1;
                if (o_done || o_fault) begin
                    ended = 1;
                end else begin
                    if (o_bus_req) reqCycles++;
                    if (!o_stall) stallOk = 0;
                end
            end
            checkOutput({name, "_ended"}, {31'd0, ended}, 32'd1);
            checkOutput({name, "_cycles"}, cycles, expCycles);
            checkOutput({name, "_req_cycles"}, reqCycles, expReq);
            checkOutput({name, "_stall_held"}, {31'd0, stallOk}, 32'd1);
            checkOutput({name, "_stall_end"}, {31'd0, o_stall}, 32'd0);
            checkOutput({name, "_req_end"}, {31'd0, o_bus_req}, 32'd0);
        end
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        #1 i_rst = 1'b1;
        #2;
        checkOutput("rst_stall", {31'd0, o_stall}, 32'd0);
        checkOutput("rst_done", {31'd0, o_done}, 32'd0);
        checkOutput("rst_fault", {31'd0, o_fault}, 32'd0);
        checkOutput("rst_req", {31'd0, o_bus_req}, 32'd0);
        checkOutput("rst_we", {31'd0, o_bus_we}, 32'd0);
        checkOutput("rst_rdata", o_rdata, 32'd0);
        checkOutput("rst_bus_addr", o_bus_addr, 32'd0);
        checkOutput("rst_bus_wdata", o_bus_wdata, 32'd0);
        checkOutput("rst_bus_mask", {28'd0, o_bus_mask}, 32'd0);
        repeat (2) @(negedge i_clk);
        i_rst = 1'b0;

        //             name     ren   wen   f3    addr           wdata          d  r  resp           kind expRdata       mask     busWdata       cyc req
        applyStimulus("sb",     1'b0, 1'b1, 3'd0, 32'h0000_1003, 32'h0000_00AB, 2, 1, 32'h0,         0, 32'h0000_0000, 4'b1000, 32'hABAB_ABAB, 4, 2);
        applyStimulus("lb",     1'b1, 1'b0, 3'd0, 32'h0000_2001, 32'h0,         1, 1, 32'h0000_8000, 0, 32'hFFFF_FF80, 4'hF,    32'h0,         4, 1);
        applyStimulus("lbu",    1'b1, 1'b0, 3'd4, 32'h0000_2001, 32'h0,         2, 2, 32'h0000_8000, 0, 32'h0000_0080, 4'hF,    32'h0,         6, 2);
        applyStimulus("lh",     1'b1, 1'b0, 3'd1, 32'h0000_2002, 32'h0,         1, 1, 32'h8001_0000, 0, 32'hFFFF_8001, 4'hF,    32'h0,         4, 1);
        applyStimulus("lw",     1'b1, 1'b0, 3'd2, 32'h0000_2004, 32'h0,         1, 1, 32'h1234_5678, 0, 32'h1234_5678, 4'hF,    32'h0,         4, 1);
        applyStimulus("sh",     1'b0, 1'b1, 3'd1, 32'h0000_1002, 32'h0000_BEEF, 1, 1, 32'h0,         0, 32'h1234_5678, 4'b1100, 32'hBEEF_BEEF, 3, 1);
        applyStimulus("sw",     1'b0, 1'b1, 3'd2, 32'h0000_1004, 32'hDEAD_BEEF, 1, 1, 32'h0,         0, 32'h1234_5678, 4'hF,    32'hDEAD_BEEF, 3, 1);
        applyStimulus("lhu",    1'b1, 1'b0, 3'd5, 32'h0000_2000, 32'h0,         1, 1, 32'h1234_F00D, 0, 32'h0000_F00D, 4'hF,    32'h0,         4, 1);
        applyStimulus("sb0",    1'b0, 1'b1, 3'd0, 32'h0000_1000, 32'h1234_5677, 1, 1, 32'h0,         0, 32'h0000_F00D, 4'b0001, 32'h7777_7777, 3, 1);
        applyStimulus("lw_mis", 1'b1, 1'b0, 3'd2, 32'h0000_2002, 32'h0,         1, 1, 32'h0,         1, 32'h0000_F00D, 4'hF,    32'h0,         0, 0);
        applyStimulus("sh_mis", 1'b0, 1'b1, 3'd1, 32'h0000_1001, 32'h0,         1, 1, 32'h0,         1, 32'h0000_F00D, 4'hF,    32'h0,         0, 0);
        applyStimulus("rw_both",1'b1, 1'b1, 3'd2, 32'h0000_1000, 32'h0,         1, 1, 32'h0,         1, 32'h0000_F00D, 4'hF,    32'h0,         0, 0);
        applyStimulus("ld_f3_3",1'b1, 1'b0, 3'd3, 32'h0000_0000, 32'h0,         1, 1, 32'h0,         1, 32'h0000_F00D, 4'hF,    32'h0,         0, 0);
        applyStimulus("st_f3_4",1'b0, 1'b1, 3'd4, 32'h0000_0000, 32'h0,         1, 1, 32'h0,         1, 32'h0000_F00D, 4'hF,    32'h0,         0, 0);
        applyStimulus("tmo",    1'b1, 1'b0, 3'd2, 32'h0000_3000, 32'h0,         0, 1, 32'h0,         2, 32'h0000_F00D, 4'hF,    32'h0,         6, 4);
        applyStimulus("lw_post",1'b1, 1'b0, 3'd2, 32'h0000_3004, 32'h0,         1, 1, 32'hCAFE_0001, 0, 32'hCAFE_0001, 4'hF,    32'h0,         4, 1);

        // Reset while waiting for read data; the late rvalid must be ignored
        @(negedge i_clk);
        gntDelay = 1;
        rvalidDelay = 3;
        respWord = 32'hA5A5_5A5A;
        busAddrQ.push_back(32'h0000_2008);
        busWeQ.push_back(1'b0);
        busMaskQ.push_back(4'hF);
        busWdataQ.push_back(32'h0);
        i_valid = 1'b1;
        i_dmem_ren = 1'b1;
        i_funct3 = 3'd2;
        i_addr = 32'h0000_2008;
        @(negedge i_clk);
        i_valid = 1'b0;
        i_dmem_ren = 1'b0;
        @(negedge i_clk);
        #1;
        checkOutput("rst_wait_stall_pre", {31'd0, o_stall}, 32'd1);
        i_rst = 1'b1;
        #1;
        checkOutput("rst_wait_req", {31'd0, o_bus_req}, 32'd0);
        checkOutput("rst_wait_stall", {31'd0, o_stall}, 32'd0);
        checkOutput("rst_wait_done", {31'd0, o_done}, 32'd0);
        checkOutput("rst_wait_rdata", o_rdata, 32'd0);
        @(negedge i_clk);
        i_rst = 1'b0;
        repeat (4) @(negedge i_clk);
        #1;
        checkOutput("late_rvalid_rdata", o_rdata, 32'd0);
        checkOutput("late_rvalid_stall", {31'd0, o_stall}, 32'd0);

        applyStimulus("lb_after_rst", 1'b1, 1'b0, 3'd0, 32'h0000_2003, 32'h0, 1, 1, 32'h7F00_0000, 0, 32'h0000_007F, 4'hF, 32'h0, 4, 1);

        repeat (3) @(negedge i_clk);
        checkOutput("sb_resp_drained", expFaultQ.size(), 32'd0);
        checkOutput("sb_bus_drained", busAddrQ.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCompared, nMismatched);
        $finish;
    end

endmodule

// File: doc/dmem_seq.md
Name: dmem_seq

Overview:
- Multicycle data-memory access sequencer in the MEM stage of the RV32I core.
- Inputs: decoded load/store enables, funct3, effective address and store data.
- Drives a req/gnt/rvalid data bus, generates byte masks and lane-replicated store data, and formats load data with sign/zero extension.
- Stalls the pipeline until the access completes; reports misaligned/illegal accesses and bus timeouts as a one-cycle fault.

Parameters:
- TIMEOUT, 255: max cycles spent in REQ or WAIT before a fault is raised; 0 disables the timeout.
- CNT_W, 8: timeout counter width; must satisfy TIMEOUT < 2**CNT_W.

Ports:
- i_clk  in  1  clock, rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_valid  in  1  MEM-stage instruction valid.
- i_dmem_ren  in  1  load decoded.
- i_dmem_wen  in  1  store decoded.
- i_funct3  in  3  access size/sign (inst[14:12]).
- i_addr  in  32  effective byte address.
- i_wdata  in  32  store data, rs2 value.
- o_stall  out  1  freeze the pipeline.
- o_done  out  1  access completed, one-cycle pulse.
- o_rdata  out  32  formatted load result.
- o_fault  out  1  misaligned/illegal/timeout, one-cycle pulse.
- o_bus_req  out  1  bus request.
- o_bus_we  out  1  1 = write.
- o_bus_addr  out  32  word-aligned address, {addr[31:2],2'b00}.
- o_bus_wdata  out  32  lane-replicated store data.
- o_bus_mask  out  4  byte enables.
- i_bus_gnt  in  1  request accepted.
- i_bus_rvalid  in  1  read data valid.
- i_bus_rdata  in  32  read word.

Behaviour:
- States: IDLE, REQ, WAIT, DONE; binary encoded.
- Reset (async, immediate): state=IDLE; o_bus_req, o_bus_we, o_stall, o_done, o_fault = 0; o_rdata, o_bus_addr, o_bus_wdata = 0; o_bus_mask = 0; counter = 0. Reset during REQ/WAIT abandons the transaction; no response is expected afterwards.
- Access request: i_valid & (ren ^ wen).
- Fault checks, evaluated in IDLE:
  - ren & wen both set.
  - Load funct3 in {3,6,7}; store funct3 > 2.
  - Halfword with addr[0] = 1; word with addr[1:0] != 0.
  - On fault: o_fault = 1 for one cycle, no bus activity, no stall, stay IDLE.
- IDLE with a legal request:
  - Latch addr[1:0], funct3, we, mask and wdata into registers.
  - o_stall = 1 combinationally in the same cycle; next state REQ.
- REQ:
  - o_bus_req = 1; addr, we, mask and wdata are held stable until i_bus_gnt.
  - On gnt: store -> DONE; load -> WAIT.
  - Req drops the cycle after gnt. o_stall = 1.
- WAIT:
  - On i_bus_rvalid, register the formatted data into o_rdata; go to DONE.
  - i_bus_rvalid is ignored outside WAIT; the bus guarantees rvalid arrives at least 1 cycle after gnt.
- DONE: o_done = 1, o_stall = 0, next state IDLE. The next request is accepted from IDLE one cycle later, so back-to-back accesses take a minimum of 3 cycles for a store and 4 for a load.
- o_rdata holds its value until the next load completes; stores do not change it.
- Timeout:
  - The counter clears on entry to REQ and on the REQ->WAIT transition, and increments each cycle in REQ/WAIT.
  - When counter == TIMEOUT and TIMEOUT != 0: o_fault pulse, o_stall = 0, o_bus_req = 0, return to IDLE.
  - A gnt/rvalid arriving in that same cycle is ignored.
- Store masks and data:
  - SB: mask = 4'b0001 << addr[1:0]; wdata = {4{wdata[7:0]}}.
  - SH: mask = 4'b0011 << {addr[1],1'b0}; wdata = {2{wdata[15:0]}}.
  - SW: mask = 4'hF.
  - For loads, mask = 4'hF.
- Load extraction: select the byte or half-word via the latched addr[1:0].
  - LB/LH sign-extend; LBU/LHU zero-extend.
  - LW passes the full word.

Decomposition:
- Package dmem_pkg holds:
  - funct3 constants F3_B=0, F3_H=1, F3_W=2, F3_BU=4, F3_HU=5.
  - State encoding IDLE=0, REQ=1, WAIT=2, DONE=3.
- One combinational sub-module, dmem_lane_fmt, handles mask and wdata generation plus load extraction/extension.
- The FSM, timeout counter and latches stay in dmem_seq.

Test Plan:
- SB addr=0x1003 wdata=0xAB, gnt after 2 cycles -> bus_addr=0x1000, mask=4'b1000, wdata=0xABABABAB; o_done in cycle 4; o_stall high for cycles 1-3.
- LB addr=0x2001, rdata=0x0000_8000 -> o_rdata=0xFFFFFF80. LBU on the same data -> 0x00000080.
- LH addr=0x2002, rdata=0x8001_0000 -> o_rdata=0xFFFF8001. LW addr=0x2004 -> o_rdata = rdata unchanged.
- LW addr=0x2002; SH addr=0x1001; ren&wen both set; load funct3=3 -> o_fault pulse each; o_bus_req never asserted; o_stall stays 0.
- TIMEOUT=4, gnt never asserted -> o_fault exactly 4 cycles after entering REQ; req drops; FSM returns to IDLE and accepts the next load.
- i_rst asserted in WAIT -> o_bus_req, o_stall, o_done drop immediately; a late rvalid after reset does not update o_rdata.
